cpu_boot_sequencer: RTL and testbench
=====================================

CPU_BOOT_SEQUENCER -- requirements
Module: cpu_boot_sequencer

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 64, max instruction words per program load.
REQ-002 SHALL have parameter RST_CYCLES, default 2, CPU reset pulse length between load and run.
REQ-003 SHALL have port clk input 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset input 1: reset is asynchronous and active-low.
REQ-005 SHALL have ports host_valid input 1, host_ready output 1, host_instr input 32, host_last input 1: program-word stream; host_last marks the final word.
REQ-006 SHALL have port run_cycles input 16: number of CPU execution cycles, sampled when the last word is accepted.
REQ-007 SHALL have ports cpu_reset output 1 (active-high CPU reset), cpu_load output 1 (CPU LoadInstructions), cpu_instr output 32 (CPU Instruction), cpu_out input 32 (CPU out).
REQ-008 SHALL have ports busy output 1, done output 1, err output 1, result output 32, load_count output 7 (log2(IMEM_DEPTH)+1 bits).

Function
REQ-009 SHALL implement states IDLE, LOAD, CPU_RST, RUN, FIN.
REQ-010 IDLE: host_ready=1, cpu_reset=1, cpu_load=0, busy=0; an accepted word (host_valid&host_ready) moves to LOAD, clears load_count and err, and counts as word 0.
REQ-011 LOAD: host_ready=1, cpu_reset=0, busy=1; each accepted word increments load_count.
REQ-012 SHALL register each accepted word: cpu_load=1 and cpu_instr=host_instr exactly one cycle after acceptance; cpu_load=0 on any cycle after a non-accepting cycle (bubble); cpu_instr holds its last value.
REQ-013 Accepting a word with host_last=1 (in IDLE or LOAD) SHALL latch run_cycles and move to CPU_RST.
REQ-014 Accepting word number IMEM_DEPTH-1 with host_last=0 SHALL set err=1, move to FIN, and drop host_ready the next cycle; that word is still forwarded to the CPU.
REQ-015 CPU_RST: host_ready=0, cpu_load=0 once the last word is forwarded, cpu_reset=1 for exactly RST_CYCLES cycles, then RUN.
REQ-016 RUN: cpu_reset=0, 16-bit cycle counter counts from 0; when counter equals latched run_cycles, result<=cpu_out and move to FIN; run_cycles=0 captures on the first RUN cycle.
REQ-017 FIN: done=1 for exactly one cycle, busy=0 from FIN, then IDLE; result and err SHALL hold until the next word is accepted in IDLE.
REQ-018 host_valid in CPU_RST, RUN, FIN SHALL be ignored (host_ready=0).
REQ-019 load_count SHALL saturate at IMEM_DEPTH and never wrap.

Reset
REQ-020 Reset low SHALL asynchronously force IDLE, cpu_reset=1, cpu_load=0, cpu_instr=0, host_ready=0 while asserted, busy=0, done=0, err=0, result=0, load_count=0, counters=0.
REQ-021 Reset asserted mid-LOAD or mid-RUN SHALL abandon the operation; no done pulse, no result update.
REQ-022 host_ready SHALL rise on the first clock edge after Reset deasserts.

Configuration
REQ-023 Macro BOOT_TIMEOUT_EN SHALL, when defined, add a 8-bit idle counter in LOAD: 255 consecutive cycles without an accepted word set err=1 and move to FIN (done pulse, result unchanged).
REQ-024 Without BOOT_TIMEOUT_EN, LOAD SHALL wait indefinitely for words and err SHALL only result from REQ-014.

Verification
REQ-025 Load 3 words back-to-back (0x200101A7, 0x2002005C, last 0x00221820), run_cycles=10 -> cpu_load high 3 consecutive cycles with matching cpu_instr, cpu_reset high 2 cycles, done after 11 RUN cycles, result = cpu_out at that cycle, load_count=3.
REQ-026 Same program with host_valid low 2 cycles between words 1 and 2 -> cpu_load low exactly 2 cycles in the gap, instruction order preserved, same result.
REQ-027 Stream 64 words, none with host_last -> err=1, done pulse, host_ready=0 after word 63, load_count=64, cpu_reset never pulsed.
REQ-028 Single word with host_last=1, run_cycles=0 -> RST 2 cycles, result captured first RUN cycle, done pulse.
REQ-029 Reset low in RUN cycle 5 of 20 -> immediate IDLE, cpu_reset=1, done never pulses, result=0.
REQ-030 With BOOT_TIMEOUT_EN, 1 word then 255 idle cycles -> err=1, done pulse; without it, still in LOAD with busy=1.

Source files
------------

// File: rtl/cpu_boot_sequencer.sv
// Boot sequencer: streams a host program into the CPU instruction memory, pulses CPU reset,
// runs the CPU for run_cycles+1 cycles and captures cpu_out. Define BOOT_TIMEOUT_EN for a LOAD idle timeout.
module cpu_boot_sequencer #(
    parameter int IMEM_DEPTH = 64,
    parameter int RST_CYCLES = 2,
    localparam int CW = $clog2(IMEM_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          host_valid,
    output logic          host_ready,
    input  logic [31:0]   host_instr,
    input  logic          host_last,
    input  logic [15:0]   run_cycles,
    output logic          cpu_reset,
    output logic          cpu_load,
    output logic [31:0]   cpu_instr,
    input  logic [31:0]   cpu_out,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [31:0]   result,
    output logic [CW-1:0] load_count,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_CPU_RST = 3'd2,
        S_RUN     = 3'd3,
        S_FIN     = 3'd4
    } state_t;

    // Handshake: a word transfers on a rising edge where host_valid && host_ready are both high;
    // host_ready is registered, so it only changes on the edge after the state decision.
    state_t        state_q, state_d;
    logic          host_ready_q, host_ready_d;
    logic          cpu_reset_q, cpu_reset_d;
    logic          cpu_load_q, cpu_load_d;
    logic [31:0]   cpu_instr_q, cpu_instr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [31:0]   result_q, result_d;
    logic [CW-1:0] load_count_q, load_count_d;
    logic [15:0]   run_cycles_q, run_cycles_d;
    logic [15:0]   cyc_q, cyc_d;
`ifdef BOOT_TIMEOUT_EN
    logic [7:0]    idle_q, idle_d;
`endif

    logic          accept;
    logic [CW-1:0] word_idx;

    always_comb begin
        state_d      = state_q;
        cpu_instr_d  = cpu_instr_q;
        err_d        = err_q;
        result_d     = result_q;
        load_count_d = load_count_q;
        run_cycles_d = run_cycles_q;
        cyc_d        = cyc_q;
`ifdef BOOT_TIMEOUT_EN
        idle_d       = idle_q;
`endif
        accept   = host_valid & host_ready_q;
        word_idx = (state_q == S_IDLE) ? '0 : load_count_q;

        cpu_load_d = accept;
        if (accept) cpu_instr_d = host_instr;

        case (state_q)
            S_IDLE, S_LOAD: begin
                if (accept) begin
`ifdef BOOT_TIMEOUT_EN
                    idle_d = '0;
`endif
                    if (state_q == S_IDLE) begin
                        err_d        = 1'b0;
                        load_count_d = CW'(1);
                    end else if (load_count_q != CW'(IMEM_DEPTH)) begin
                        load_count_d = load_count_q + CW'(1);
                    end
                    if (host_last) begin
                        run_cycles_d = run_cycles;
                        cyc_d        = '0;
                        state_d      = S_CPU_RST;
                    end else if (word_idx == CW'(IMEM_DEPTH - 1)) begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
`ifdef BOOT_TIMEOUT_EN
                else if (state_q == S_LOAD) begin
                    if (idle_q == 8'd254) begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        idle_d = idle_q + 8'd1;
                    end
                end
`endif
            end
            S_CPU_RST: begin
                // First CPU_RST cycle still carries the final cpu_load; the reset pulse follows it.
                if (cyc_q == 16'(RST_CYCLES)) begin
                    cyc_d   = '0;
                    state_d = S_RUN;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            S_RUN: begin
                if (cyc_q == run_cycles_q) begin
                    result_d = cpu_out;
                    state_d  = S_FIN;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        host_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
        busy_d       = (state_d == S_LOAD) || (state_d == S_CPU_RST) || (state_d == S_RUN);
        done_d       = (state_d == S_FIN);
        cpu_reset_d  = (state_d == S_IDLE) || ((state_q == S_CPU_RST) && (state_d == S_CPU_RST));
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= S_IDLE;
            host_ready_q <= 1'b0;
            cpu_reset_q  <= 1'b1;
            cpu_load_q   <= 1'b0;
            cpu_instr_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            result_q     <= '0;
            load_count_q <= '0;
            run_cycles_q <= '0;
            cyc_q        <= '0;
`ifdef BOOT_TIMEOUT_EN
            idle_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            host_ready_q <= host_ready_d;
            cpu_reset_q  <= cpu_reset_d;
            cpu_load_q   <= cpu_load_d;
            cpu_instr_q  <= cpu_instr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            result_q     <= result_d;
            load_count_q <= load_count_d;
            run_cycles_q <= run_cycles_d;
            cyc_q        <= cyc_d;
`ifdef BOOT_TIMEOUT_EN
            idle_q       <= idle_d;
`endif
        end
    end

    assign host_ready = host_ready_q;
    assign cpu_reset  = cpu_reset_q;
    assign cpu_load   = cpu_load_q;
    assign cpu_instr  = cpu_instr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign result     = result_q;
    assign load_count = load_count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_cpu_boot_sequencer.sv
// Directed bench for cpu_boot_sequencer: program loads, gaps, overflow error, run capture,
// reset abort and the LOAD idle timeout (BOOT_TIMEOUT_EN).
module tb_cpu_boot_sequencer;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd3;

    logic        clk = 1'b0;
    logic        Reset;
    logic        host_valid = 1'b0;
    logic        host_ready;
    logic [31:0] host_instr = '0;
    logic        host_last = 1'b0;
    logic [15:0] run_cycles = '0;
    logic        cpu_reset;
    logic        cpu_load;
    logic [31:0] cpu_instr;
    logic [31:0] cpu_out = '0;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] result;
    logic [6:0]  load_count;
    logic [2:0]  dbg_state;

    cpu_boot_sequencer #(.IMEM_DEPTH(64), .RST_CYCLES(2)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .host_instr (host_instr),
        .host_last  (host_last),
        .run_cycles (run_cycles),
        .cpu_reset  (cpu_reset),
        .cpu_load   (cpu_load),
        .cpu_instr  (cpu_instr),
        .cpu_out    (cpu_out),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .result     (result),
        .load_count (load_count),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int unsigned tick = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];

    int          done_cnt, rst_cnt, run_cnt, gap_cnt;
    bit          aborted;
    logic [31:0] last_out;
    logic [31:0] prev_result;
    bit          done_seen;

    task automatic step();
        @(posedge clk);
        #1;
        tick++;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int i);
        logic [31:0] prog [3];
        prog = '{32'h200101A7, 32'h2002005C, 32'h00221820};
        if (i < 3) return prog[i];
        return 32'h1000_0000 + 32'(i);
    endfunction

    // driver + per-cycle monitor; samples #1 after each edge, then drives for the next edge
    task automatic run_program(input int n_words, input bit use_last, input int gap_after,
                               input int gap_len, input logic [15:0] rc, input bit junk,
                               input int abort_run, input int max_cyc);
        int wi = 0;
        int gap_left = 0;
        done_cnt = 0; rst_cnt = 0; run_cnt = 0; gap_cnt = 0; aborted = 0;
        exp_q.delete();
        run_cycles = rc;
        for (int c = 0; c < max_cyc; c++) begin
            if (cpu_load) begin
                if (exp_q.size() == 0) check("stray_cpu_load", {31'b0, cpu_load}, 32'd0);
                else check("cpu_instr", cpu_instr, exp_q.pop_front());
            end else if (dbg_state == ST_LOAD) begin
                gap_cnt++;
            end
            if (busy && cpu_reset) rst_cnt++;
            if (done) begin
                done_cnt++;
                break;
            end
            if (dbg_state == ST_RUN) begin
                run_cnt++;
                if (abort_run != 0 && run_cnt == abort_run) begin
                    aborted = 1;
                    break;
                end
            end
            cpu_out = 32'hBEEF_0000 + 32'(tick);
            if (dbg_state == ST_RUN) last_out = cpu_out;
            if (wi < n_words && gap_left == 0) begin
                host_valid = 1'b1;
                host_instr = word_of(wi);
                host_last  = use_last && (wi == n_words - 1);
            end else if (wi >= n_words && junk) begin
                host_valid = 1'b1;
                host_instr = 32'hDEAD_BEEF;
                host_last  = 1'b1;
            end else begin
                host_valid = 1'b0;
            end
            if (gap_left > 0) gap_left--;
            if (host_valid && host_ready && wi < n_words) begin
                exp_q.push_back(host_instr);
                if (wi == gap_after) gap_left = gap_len;
                wi++;
            end
            step();
        end
        host_valid = 1'b0;
        host_last  = 1'b0;
    endtask

    task automatic check_back_to_idle(input string tag);
        step();
        check({tag, "_done_low"}, {31'b0, done}, 32'd0);
        check({tag, "_state_idle"}, {29'b0, dbg_state}, {29'b0, ST_IDLE});
        check({tag, "_ready"}, {31'b0, host_ready}, 32'd1);
    endtask

    initial begin
        Reset = 1'b0;
        #2;
        step();
        step();
        check("rst_host_ready", {31'b0, host_ready}, 32'd0);
        check("rst_cpu_reset", {31'b0, cpu_reset}, 32'd1);
        check("rst_cpu_load", {31'b0, cpu_load}, 32'd0);
        check("rst_cpu_instr", cpu_instr, 32'd0);
        check("rst_busy_done_err", {29'b0, busy, done, err}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_load_count", {25'b0, load_count}, 32'd0);
        check("rst_state", {29'b0, dbg_state}, {29'b0, ST_IDLE});
        Reset = 1'b1;
        #1;
        check("rel_ready_before_edge", {31'b0, host_ready}, 32'd0);
        step();
        check("rel_ready_after_edge", {31'b0, host_ready}, 32'd1);

        // three words back to back, run 10, junk valid after the last word must be ignored
        run_program(3, 1, -1, 0, 16'd10, 1, 0, 100);
        check("b2b_done", 32'(done_cnt), 32'd1);
        check("b2b_rst_cycles", 32'(rst_cnt), 32'd2);
        check("b2b_run_cycles", 32'(run_cnt), 32'd11);
        check("b2b_gap", 32'(gap_cnt), 32'd0);
        check("b2b_result", result, last_out);
        check("b2b_load_count", {25'b0, load_count}, 32'd3);
        check("b2b_err", {31'b0, err}, 32'd0);
        check("b2b_busy_fin", {31'b0, busy}, 32'd0);
        check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
        prev_result = result;
        check_back_to_idle("b2b");
        check("b2b_result_hold", result, prev_result);

        // two-cycle bubble between words 1 and 2
        run_program(3, 1, 1, 2, 16'd10, 0, 0, 100);
        check("gap_done", 32'(done_cnt), 32'd1);
        check("gap_cpu_load_low", 32'(gap_cnt), 32'd2);
        check("gap_rst_cycles", 32'(rst_cnt), 32'd2);
        check("gap_run_cycles", 32'(run_cnt), 32'd11);
        check("gap_result", result, last_out);
        check("gap_load_count", {25'b0, load_count}, 32'd3);
        check_back_to_idle("gap");

        // 64 words without host_last overflows the instruction memory
        run_program(64, 0, -1, 0, 16'd5, 0, 0, 200);
        check("ovf_done", 32'(done_cnt), 32'd1);
        check("ovf_err", {31'b0, err}, 32'd1);
        check("ovf_ready_low", {31'b0, host_ready}, 32'd0);
        check("ovf_load_count", {25'b0, load_count}, 32'd64);
        check("ovf_no_cpu_reset", 32'(rst_cnt), 32'd0);
        check("ovf_no_run", 32'(run_cnt), 32'd0);
        check("ovf_queue_empty", 32'(exp_q.size()), 32'd0);
        check_back_to_idle("ovf");
        check("ovf_err_hold", {31'b0, err}, 32'd1);

        // single word, run_cycles = 0
        run_program(1, 1, -1, 0, 16'd0, 0, 0, 50);
        check("one_done", 32'(done_cnt), 32'd1);
        check("one_rst_cycles", 32'(rst_cnt), 32'd2);
        check("one_run_cycles", 32'(run_cnt), 32'd1);
        check("one_result", result, last_out);
        check("one_err_cleared", {31'b0, err}, 32'd0);
        check("one_load_count", {25'b0, load_count}, 32'd1);
        prev_result = result;
        check_back_to_idle("one");

        // one word then silence in LOAD
        run_program(1, 0, -1, 0, 16'd3, 0, 0, 300);
`ifdef BOOT_TIMEOUT_EN
        check("tmo_done", 32'(done_cnt), 32'd1);
        check("tmo_err", {31'b0, err}, 32'd1);
        check("tmo_idle_cycles", 32'(gap_cnt), 32'd254);
        check("tmo_result_hold", result, prev_result);
        check_back_to_idle("tmo");
`else
        check("tmo_no_done", 32'(done_cnt), 32'd0);
        check("tmo_still_load", {29'b0, dbg_state}, {29'b0, ST_LOAD});
        check("tmo_busy", {31'b0, busy}, 32'd1);
        check("tmo_err", {31'b0, err}, 32'd0);
        Reset = 1'b0;
        #1;
        check("tmo_rst_state", {29'b0, dbg_state}, {29'b0, ST_IDLE});
        step();
        Reset = 1'b1;
        step();
`endif

        // reset in RUN cycle 5 of 20
        run_program(3, 1, -1, 0, 16'd20, 0, 5, 100);
        check("abt_reached_run5", {31'b0, aborted}, 32'd1);
        Reset = 1'b0;
        #1;
        check("abt_state", {29'b0, dbg_state}, {29'b0, ST_IDLE});
        check("abt_cpu_reset", {31'b0, cpu_reset}, 32'd1);
        check("abt_result", result, 32'd0);
        check("abt_busy", {31'b0, busy}, 32'd0);
        check("abt_load_count", {25'b0, load_count}, 32'd0);
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done) done_seen = 1;
        end
        check("abt_no_done", {31'b0, done_seen}, 32'd0);
        check("abt_ready_low", {31'b0, host_ready}, 32'd0);
        Reset = 1'b1;
        step();
        check("abt_ready_after", {31'b0, host_ready}, 32'd1);
        check("abt_result_after", result, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
